// File: rtl/min_search_ctrl_if.sv
// Bundle between min_search_ctrl and its neighbours: job request, ED RAM read port,
// min-finder stream/results and the result handshake.
interface min_search_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              start_valid;
  logic              start_ready;
  logic [ADDR_W-1:0] start_base;
  logic [ADDR_W:0]   start_count;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  logic              mf_enable;
  logic [DATA_W-1:0] mf_ed_in;
  logic [DATA_W-1:0] mf_node_in;
  logic [DATA_W-1:0] mf_min1_ed;
  logic [DATA_W-1:0] mf_min2_ed;
  logic [DATA_W-1:0] mf_min1_node;
  logic [DATA_W-1:0] mf_min2_node;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_min1_ed;
  logic [DATA_W-1:0] res_min2_ed;
  logic [DATA_W-1:0] res_min1_node;
  logic [DATA_W-1:0] res_min2_node;
  logic              res_err_empty;

  logic              busy;

  // Controller side
  modport slave (
    input  start_valid, start_base, start_count,
    input  mem_rd_data,
    input  mf_min1_ed, mf_min2_ed, mf_min1_node, mf_min2_node,
    input  res_ready,
    output start_ready,
    output mem_rd_en, mem_rd_addr,
    output mf_enable, mf_ed_in, mf_node_in,
    output res_valid, res_min1_ed, res_min2_ed, res_min1_node, res_min2_node, res_err_empty,
    output busy
  );

  // Scheduler / RAM / finder side
  modport master (
    output start_valid, start_base, start_count,
    output mem_rd_data,
    output mf_min1_ed, mf_min2_ed, mf_min1_node, mf_min2_node,
    output res_ready,
    input  start_ready,
    input  mem_rd_en, mem_rd_addr,
    input  mf_enable, mf_ed_in, mf_node_in,
    input  res_valid, res_min1_ed, res_min2_ed, res_min1_node, res_min2_node, res_err_empty,
    input  busy
  );
endinterface

// File: rtl/min_search_ctrl.sv
// Job sequencer for the two-minimum finder: streams ED words from RAM, frames the finder
// enable window and returns min1/min2 results. Define MIN_SEARCH_CTRL_PERF_EN for perf counters.
module min_search_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  min_search_ctrl_if.slave bus
`ifdef MIN_SEARCH_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_jobs
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    CAPTURE,
    RESULT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   issued_q;

  logic accept;
  logic rd_en;
  logic start_ready;
  logic res_valid;
  logic busy;

  logic              mf_enable_q;
  logic [DATA_W-1:0] node_q;
  logic [DATA_W-1:0] res_min1_ed_q;
  logic [DATA_W-1:0] res_min2_ed_q;
  logic [DATA_W-1:0] res_min1_node_q;
  logic [DATA_W-1:0] res_min2_node_q;
  logic              res_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // start_ready is masked by rst so every handshake output reads 0 while reset is held
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    rd_en       = 1'b0;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy        = 1'b0;
        start_ready = ~rst;
        if (bus.start_valid) begin
          accept    = 1'b1;
          state_nxt = (bus.start_count == '0) ? RESULT : STREAM;
        end
      end
      STREAM: begin
        rd_en = 1'b1;
        if ((issued_q + 1'b1) == count_q) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read-address generator, enable/node pipeline stage and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      count_q         <= '0;
      issued_q        <= '0;
      mf_enable_q     <= 1'b0;
      node_q          <= '0;
      res_min1_ed_q   <= '1;
      res_min2_ed_q   <= '1;
      res_min1_node_q <= '1;
      res_min2_node_q <= '1;
      res_err_q       <= 1'b0;
    end else begin
      mf_enable_q <= rd_en;
      node_q      <= {{(DATA_W-ADDR_W){1'b0}}, addr_q};
      if (accept) begin
        addr_q   <= bus.start_base;
        count_q  <= bus.start_count;
        issued_q <= '0;
        if (bus.start_count == '0) begin
          res_min1_ed_q   <= '1;
          res_min2_ed_q   <= '1;
          res_min1_node_q <= '1;
          res_min2_node_q <= '1;
          res_err_q       <= 1'b1;
        end
      end else if (rd_en) begin
        addr_q   <= addr_q + 1'b1;
        issued_q <= issued_q + 1'b1;
      end
      if (state == CAPTURE) begin
        res_min1_ed_q   <= bus.mf_min1_ed;
        res_min2_ed_q   <= bus.mf_min2_ed;
        res_min1_node_q <= bus.mf_min1_node;
        res_min2_node_q <= bus.mf_min2_node;
        res_err_q       <= 1'b0;
      end
    end
  end

  assign bus.start_ready   = start_ready;
  assign bus.busy          = busy;
  assign bus.mem_rd_en     = rd_en;
  assign bus.mem_rd_addr   = addr_q;
  assign bus.mf_enable     = mf_enable_q;
  assign bus.mf_ed_in      = bus.mem_rd_data;
  assign bus.mf_node_in    = node_q;
  assign bus.res_valid     = res_valid;
  assign bus.res_min1_ed   = res_min1_ed_q;
  assign bus.res_min2_ed   = res_min2_ed_q;
  assign bus.res_min1_node = res_min1_node_q;
  assign bus.res_min2_node = res_min2_node_q;
  assign bus.res_err_empty = res_err_q;

`ifdef MIN_SEARCH_CTRL_PERF_EN
  logic [31:0] run_q;

  // run_q equals the cycle index since the accept edge; res_valid rises one cycle after CAPTURE
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= '0;
      perf_cycles <= '0;
      perf_jobs   <= '0;
    end else begin
      if (accept) begin
        run_q <= 32'd1;
      end else if (run_q != '1) begin
        run_q <= run_q + 32'd1;
      end
      if (accept && (bus.start_count == '0)) begin
        perf_cycles <= 32'd1;
      end else if (state == CAPTURE) begin
        perf_cycles <= (run_q == '1) ? run_q : run_q + 32'd1;
      end
      if (res_valid && bus.res_ready && (perf_jobs != '1)) begin
        perf_jobs <= perf_jobs + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_min_search_ctrl.sv
// Directed bench for min_search_ctrl with an ED RAM model and a two-minimum finder model.
// Build with MIN_SEARCH_CTRL_PERF_EN defined to also check the perf counters.
module tb_min_search_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  min_search_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MIN_SEARCH_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_jobs;
`endif

  min_search_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MIN_SEARCH_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_jobs   (perf_jobs)
`endif
  );

  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr];
  end

  // Finder model: clears whenever enable is low, strict-less-than update otherwise
  logic [31:0] m1e = '1, m2e = '1, m1n = '1, m2n = '1;
  always @(posedge clk) begin
    if (!bus.mf_enable) begin
      m1e <= '1; m2e <= '1; m1n <= '1; m2n <= '1;
    end else if (bus.mf_ed_in < m1e) begin
      m2e <= m1e; m2n <= m1n; m1e <= bus.mf_ed_in; m1n <= bus.mf_node_in;
    end else if (bus.mf_ed_in < m2e) begin
      m2e <= bus.mf_ed_in; m2n <= bus.mf_node_in;
    end
  end
  assign bus.mf_min1_ed   = m1e;
  assign bus.mf_min2_ed   = m2e;
  assign bus.mf_min1_node = m1n;
  assign bus.mf_min2_node = m2n;

  int errors = 0;
  int checks = 0;

  // Per-job monitor, sampled on the falling edge; cyc counts cycles after the accept edge
  int cyc = 0, acc_count = 0, hs_count = 0;
  int en_cnt = 0, en_first = -1, valid_cycle = -1, hs_cycle = -1;
  int low_run = 0, last_gap = 0;
  int rd_q[$];
  int node_q[$];
  bit pend = 0, unstable = 0, ready_bad = 0;
  logic [127:0] snap;
  logic [31:0] hs1e, hs2e, hs1n, hs2n;
  logic hs_err;

  always @(negedge clk) begin
    if (pend) begin
      cyc = 1;
      rd_q.delete();
      node_q.delete();
      en_cnt = 0; en_first = -1; valid_cycle = -1; hs_cycle = -1;
      unstable = 0; ready_bad = 0;
    end else begin
      cyc++;
    end
    pend = 0;
    if (bus.mem_rd_en) rd_q.push_back(int'(bus.mem_rd_addr));
    if (bus.mf_enable) begin
      node_q.push_back(int'(bus.mf_node_in));
      en_cnt++;
      if (en_first < 0) en_first = cyc;
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
    if (bus.res_valid) begin
      if (valid_cycle < 0) begin
        valid_cycle = cyc;
        snap = {bus.res_min1_ed, bus.res_min2_ed, bus.res_min1_node, bus.res_min2_node};
      end else if ({bus.res_min1_ed, bus.res_min2_ed, bus.res_min1_node, bus.res_min2_node} != snap) begin
        unstable = 1;
      end
      if (bus.start_ready) ready_bad = 1;
      if (bus.res_ready) begin
        hs_count++;
        hs_cycle = cyc;
        hs1e = bus.res_min1_ed; hs2e = bus.res_min2_ed;
        hs1n = bus.res_min1_node; hs2n = bus.res_min2_node;
        hs_err = bus.res_err_empty;
      end
    end
    if (bus.start_valid && bus.start_ready && !rst) begin
      pend = 1;
      acc_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Presents a job and returns in the cycle after its accept edge
  task automatic applyStimulus(input logic [9:0] base, input logic [10:0] count);
    int a0;
    bit ok;
    a0 = acc_count;
    ok = 0;
    bus.start_base  = base;
    bus.start_count = count;
    bus.start_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      if (acc_count != a0) begin ok = 1; break; end
    end
    bus.start_valid = 1'b0;
    checkOutput("accept_seen", 32'(ok), 32'd1);
  endtask

  // Waits for the handshake, stalling res_ready for 'hold' cycles of res_valid
  task automatic waitResult(input int hold);
    int h0;
    int held;
    bit ok;
    h0 = hs_count;
    held = 0;
    ok = 0;
    bus.res_ready = (hold == 0);
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #2;
      if (hs_count != h0) begin ok = 1; break; end
      if (bus.res_valid) begin
        if (held < hold) begin bus.res_ready = 1'b0; held++; end
        else bus.res_ready = 1'b1;
      end
    end
    bus.res_ready = 1'b1;
    checkOutput("result_seen", 32'(ok), 32'd1);
  endtask

  task automatic checkJob(input string tag, input int base, input int count,
                          input logic [31:0] e1, n1, e2, n2);
    checkOutput({tag, "_rd_cnt"}, rd_q.size(), count);
    checkOutput({tag, "_en_cnt"}, en_cnt, count);
    checkOutput({tag, "_en_first"}, en_first, 2);
    checkOutput({tag, "_valid_cyc"}, valid_cycle, count + 3);
    for (int i = 0; i < count && i < rd_q.size() && i < node_q.size(); i++) begin
      checkOutput({tag, "_rd_addr"}, rd_q[i], (base + i) % 1024);
      checkOutput({tag, "_node"}, node_q[i], (base + i) % 1024);
    end
    checkOutput({tag, "_min1_ed"}, hs1e, e1);
    checkOutput({tag, "_min1_node"}, hs1n, n1);
    checkOutput({tag, "_min2_ed"}, hs2e, e2);
    checkOutput({tag, "_min2_node"}, hs2n, n2);
    checkOutput({tag, "_err"}, 32'(hs_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0000_1000 + i;
    ram[10'h010] = 7;  ram[10'h011] = 3;  ram[10'h012] = 9;  ram[10'h013] = 3;
    ram[10'h3FE] = 10; ram[10'h3FF] = 20; ram[10'h000] = 5;  ram[10'h001] = 15;
    ram[10'h020] = 8;  ram[10'h021] = 6;  ram[10'h022] = 4;
    ram[10'h030] = 5;  ram[10'h031] = 1;
    ram[10'h050] = 2;  ram[10'h051] = 9;  ram[10'h052] = 1;
    bus.start_valid = 1'b0;
    bus.start_base  = '0;
    bus.start_count = '0;
    bus.res_ready   = 1'b0;

    $display("[TB] reset values");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_start_ready", 32'(bus.start_ready), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    checkOutput("rst_mf_enable", 32'(bus.mf_enable), 32'd0);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_err", 32'(bus.res_err_empty), 32'd0);
    checkOutput("rst_min1_ed", bus.res_min1_ed, 32'hFFFF_FFFF);
    checkOutput("rst_min2_node", bus.res_min2_node, 32'hFFFF_FFFF);
    rst = 1'b0;
    #1;
    checkOutput("idle_start_ready", 32'(bus.start_ready), 32'd1);

    $display("[TB] basic job");
    applyStimulus(10'h010, 11'd4);
    waitResult(0);
    checkJob("basic", 'h010, 4, 32'd3, 32'h11, 32'd3, 32'h13);
`ifdef MIN_SEARCH_CTRL_PERF_EN
    checkOutput("perf_cycles", perf_cycles, 32'd7);
    checkOutput("perf_jobs", perf_jobs, 32'd1);
`endif

    $display("[TB] address wrap");
    applyStimulus(10'h3FE, 11'd4);
    waitResult(0);
    checkJob("wrap", 'h3FE, 4, 32'd5, 32'h000, 32'd10, 32'h3FE);

    $display("[TB] empty job");
    applyStimulus(10'h123, 11'd0);
    waitResult(0);
    checkOutput("empty_rd_cnt", rd_q.size(), 0);
    checkOutput("empty_en_cnt", en_cnt, 0);
    checkOutput("empty_valid_cyc", valid_cycle, 1);
    checkOutput("empty_err", 32'(hs_err), 32'd1);
    checkOutput("empty_min1_ed", hs1e, 32'hFFFF_FFFF);
    checkOutput("empty_min2_ed", hs2e, 32'hFFFF_FFFF);
    checkOutput("empty_min1_node", hs1n, 32'hFFFF_FFFF);
    checkOutput("empty_min2_node", hs2n, 32'hFFFF_FFFF);

    $display("[TB] backpressure and back-to-back");
    applyStimulus(10'h020, 11'd3);
    bus.start_base  = 10'h030;
    bus.start_count = 11'd2;
    bus.start_valid = 1'b1;
    waitResult(5);
    checkJob("bp", 'h020, 3, 32'd4, 32'h22, 32'd6, 32'h21);
    checkOutput("bp_hs_cyc", hs_cycle, 11);
    checkOutput("bp_stable", 32'(unstable), 32'd0);
    checkOutput("bp_start_ready_low", 32'(ready_bad), 32'd0);
    checkOutput("b2b_ready_idle", 32'(bus.start_ready), 32'd1);
    applyStimulus(10'h030, 11'd2);
    waitResult(0);
    checkJob("b2b", 'h030, 2, 32'd1, 32'h31, 32'd5, 32'h30);
    checkOutput("b2b_gap_ok", 32'(last_gap >= 3), 32'd1);

    $display("[TB] reset mid-stream");
    applyStimulus(10'h040, 11'd8);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    checkOutput("midrst_mf_enable", 32'(bus.mf_enable), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_start_ready", 32'(bus.start_ready), 32'd1);
    checkOutput("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    begin
      int h0;
      h0 = hs_count;
      repeat (12) @(posedge clk);
      #2;
      checkOutput("midrst_no_result", hs_count - h0, 0);
    end
    applyStimulus(10'h050, 11'd3);
    waitResult(0);
    checkJob("after_rst", 'h050, 3, 32'd1, 32'h52, 32'd2, 32'h50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
